// File: rtl/key_conditioner.sv
// Pushbutton conditioner: 2-flop sync, counter debounce FSM and press/release pulses per key,
// plus a maskable per-key toggle latch.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] toggle_en,
  input  logic [NUM_KEYS-1:0] toggle_clr,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle
);

  typedef enum logic [1:0] {
    ST_UP,
    ST_DOWN_WAIT,
    ST_DOWN,
    ST_UP_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] s1_q, s2_q;
  state_e              state_q [NUM_KEYS];
  state_e              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] toggle_q, toggle_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      // s2 low means the synchronised key is held
      unique case (state_q[i])
        ST_UP: begin
          if (!s2_q[i]) begin
            state_d[i] = ST_DOWN_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        ST_DOWN_WAIT: begin
          if (s2_q[i]) begin
            state_d[i] = ST_UP;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_DOWN;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          if (s2_q[i]) begin
            state_d[i] = ST_UP_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        ST_UP_WAIT: begin
          if (!s2_q[i]) begin
            state_d[i] = ST_DOWN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = ST_UP;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_UP;
          cnt_d[i]   = '0;
        end
      endcase

      level_d[i] = (state_d[i] == ST_DOWN) || (state_d[i] == ST_UP_WAIT);

      // Clear has priority; enable is looked at only while the press pulse is up
      if (toggle_clr[i]) begin
        toggle_d[i] = 1'b0;
      end else if (press_q[i] && toggle_en[i]) begin
        toggle_d[i] = ~toggle_q[i];
      end else begin
        toggle_d[i] = toggle_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= '1;
      s2_q      <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= ST_UP;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q      <= key_n;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_toggle  = toggle_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a short debounce window (8 cycles).
module tb_key_conditioner;

  logic       clk;
  logic       reset;
  logic [3:0] key_n;
  logic [3:0] toggle_en;
  logic [3:0] toggle_clr;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_toggle;

  int n_vec;
  int n_miss;
  int press_cnt [4];
  int rel_cnt   [4];
  logic [3:0] level_seen;

  key_conditioner #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .toggle_en  (toggle_en),
    .toggle_clr (toggle_clr),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
    level_seen = '0;
  endtask

  // Advance n falling edges, tallying pulses seen after each rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (key_press[i])   press_cnt[i]++;
        if (key_release[i]) rel_cnt[i]++;
      end
      level_seen = level_seen | key_level;
    end
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    reset      = 1'b1;
    key_n      = '1;
    toggle_en  = '0;
    toggle_clr = '0;
    clr_counts();
    #1;
    chk("rst_outs", {key_level, key_press, key_release, key_toggle}, 32'h0);
    cyc(2);
    reset = 1'b0;
    cyc(3);

    // 1: single clean press/release on key 0
    clr_counts();
    key_n[0] = 1'b0;
    cyc(9);
    chk("t1_pre_press", key_press, 4'b0000);
    chk("t1_pre_level", key_level, 4'b0000);
    cyc(1);
    chk("t1_press", key_press, 4'b0001);
    chk("t1_level", key_level, 4'b0001);
    cyc(1);
    chk("t1_press_1cyc", key_press, 4'b0000);
    cyc(30);
    chk("t1_no_repeat", press_cnt[0], 1);
    key_n[0] = 1'b1;
    cyc(3);
    key_n[0] = 1'b0;
    cyc(15);
    chk("t1_glitch_rel", rel_cnt[0], 0);
    chk("t1_glitch_lvl", key_level, 4'b0001);
    key_n[0] = 1'b1;
    cyc(9);
    chk("t1_pre_rel", key_release, 4'b0000);
    chk("t1_pre_rel_lvl", key_level, 4'b0001);
    cyc(1);
    chk("t1_release", key_release, 4'b0001);
    chk("t1_rel_level", key_level, 4'b0000);
    cyc(1);
    chk("t1_rel_1cyc", key_release, 4'b0000);
    cyc(3);

    // 2: bounce on key 1 is rejected, then a real hold is accepted once
    clr_counts();
    key_n[1] = 1'b0; cyc(5);
    key_n[1] = 1'b1; cyc(2);
    key_n[1] = 1'b0; cyc(5);
    key_n[1] = 1'b1; cyc(12);
    chk("t2_bounce_press", press_cnt[1], 0);
    chk("t2_bounce_level", level_seen, 4'b0000);
    clr_counts();
    key_n[1] = 1'b0; cyc(12);
    key_n[1] = 1'b1; cyc(12);
    chk("t2_hold_press", press_cnt[1], 1);
    chk("t2_hold_rel", rel_cnt[1], 1);

    // 3: toggle only on enabled key 2; key 3 press is lost
    clr_counts();
    toggle_en = 4'b0100;
    repeat (3) begin
      key_n[2] = 1'b0; cyc(12);
      key_n[2] = 1'b1; cyc(12);
    end
    chk("t3_press_cnt", press_cnt[2], 3);
    chk("t3_toggle", key_toggle, 4'b0100);
    key_n[3] = 1'b0; cyc(12);
    key_n[3] = 1'b1; cyc(12);
    chk("t3_press3", press_cnt[3], 1);
    chk("t3_lost", key_toggle, 4'b0100);

    // 4: clear beats a simultaneous enabled press, from either toggle value
    key_n[2] = 1'b0; cyc(10);
    chk("t4_press", key_press, 4'b0100);
    toggle_clr = 4'b0100; cyc(1); toggle_clr = '0;
    chk("t4_clr_from1", key_toggle, 4'b0000);
    key_n[2] = 1'b1; cyc(12);
    key_n[2] = 1'b0; cyc(10);
    toggle_clr = 4'b0100; cyc(1); toggle_clr = '0;
    chk("t4_clr_from0", key_toggle, 4'b0000);
    key_n[2] = 1'b1; cyc(12);
    key_n[2] = 1'b0; cyc(11);
    chk("t4_toggle_again", key_toggle, 4'b0100);
    key_n[2] = 1'b1; cyc(12);
    toggle_clr = 4'b0100; cyc(1); toggle_clr = '0;
    chk("t4_clr_only", key_toggle, 4'b0000);
    toggle_en = '0;

    // 5: async reset mid-count; held keys re-accepted after full latency
    key_n[3] = 1'b0; cyc(12);
    chk("t5_level3", key_level, 4'b1000);
    key_n[0] = 1'b0; cyc(7);
    reset = 1'b1;
    #1;
    chk("t5_async", {key_level, key_press, key_release, key_toggle}, 32'h0);
    cyc(2);
    reset = 1'b0;
    cyc(9);
    chk("t5_pre_press", key_press, 4'b0000);
    cyc(1);
    chk("t5_press", key_press, 4'b1001);
    chk("t5_level", key_level, 4'b1001);
    key_n = '1; cyc(12);

    // 6: simultaneous independent presses on keys 0 and 3
    key_n = 4'b0110;
    cyc(9);
    chk("t6_pre_press", key_press, 4'b0000);
    cyc(1);
    chk("t6_press", key_press, 4'b1001);
    cyc(1);
    chk("t6_press_1cyc", key_press, 4'b0000);
    chk("t6_level", key_level, 4'b1001);
    key_n = '1;
    cyc(10);
    chk("t6_release", key_release, 4'b1001);
    chk("t6_rel_level", key_level, 4'b0000);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
